// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - fetch-queue memory and core-side handshake bundle
interface instr_fetch_queue_if #(
  parameter int XLEN = 64
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential instruction fetcher with {pc, instr} queue and redirect flush
// Optional zero-latency bypass of an empty queue: define IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic queue_empty, resp, bypass, grant, push, pop;
  logic mem_req, inst_valid;

  assign queue_empty = (count_q == '0);
  assign resp        = (state_q == S_WAIT) && bus.mem_rvalid;

`ifdef IFQ_BYPASS_EN
  assign bypass = queue_empty && resp && !bus.redirect && !rst;
`else
  assign bypass = 1'b0;
`endif

  // Only one request outstanding, and only when a queue slot is guaranteed for it.
  assign mem_req    = !rst && (state_q == S_REQ) && (count_q < CW'(DEPTH));
  assign grant      = mem_req && bus.mem_gnt;
  assign inst_valid = !rst && (!queue_empty || bypass);

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = fpc_q;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_data  = bypass ? bus.mem_rdata  : data_q[rd_ptr_q];
  assign bus.inst_pc    = bypass ? inflight_pc_q  : pc_q[rd_ptr_q];

  assign pop  = inst_valid && bus.inst_ready && !bus.redirect && !queue_empty;
  assign push = resp && !bus.redirect && !rst && !(bypass && bus.inst_ready);

  always_comb begin
    state_d       = state_q;
    fpc_d         = fpc_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);

    unique case (state_q)
      S_REQ: begin
        if (grant) begin
          fpc_d         = fpc_q + XLEN'(4);
          inflight_pc_d = fpc_q;
          state_d       = S_WAIT;
        end
      end
      S_WAIT, S_DROP: begin
        if (bus.mem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A request still owed a response after redirect must have its data thrown away.
    if (bus.redirect) begin
      fpc_d    = bus.redirect_pc & ~XLEN'(3);
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (state_d == S_WAIT) state_d = S_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      fpc_q         <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= bus.mem_rdata;
      pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized bench for instr_fetch_queue against an epoch/queue reference model
module tb_instr_fetch_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  instr_fetch_queue_if #(.XLEN(XLEN)) bus ();

  instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // stimulus knobs
  int p_gnt, p_ready, p_redir, p_rst, lat_min, lat_max;
  bit force_rst, force_redir;
  logic [63:0] redir_target;

  // reference model: delivered-in-order queue plus fetch pointer; epoch bumps on every flush
  logic [63:0] mq_pc [$];
  logic [63:0] m_fpc;
  bit          m_busy;
  int          epoch;

  // memory responder
  bit          mem_pend;
  int          mem_cnt;
  logic [63:0] pend_addr;
  int          pend_epoch;

  logic [63:0] gnt_log [$];
  logic [63:0] pop_log [$];

  function automatic logic [31:0] fdata(input logic [63:0] a);
    return a[33:2] ^ 32'h0000_0013 ^ {a[63:48], 16'h0};
  endfunction

  function automatic logic [63:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    return {48'h0, 16'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    bit          live, byp, e_req, e_valid, granted, popped;
    logic [63:0] e_pc;
    @(negedge clk);
    rst              = force_rst || ($urandom_range(0, 999) < p_rst);
    bus.redirect     = force_redir || ($urandom_range(0, 999) < p_redir);
    bus.redirect_pc  = force_redir ? redir_target : rand_pc();
    bus.mem_rvalid   = mem_pend && (mem_cnt == 0);
    bus.mem_rdata    = bus.mem_rvalid ? fdata(pend_addr) : $urandom;
    bus.mem_gnt      = !mem_pend && ($urandom_range(0, 99) < p_gnt);
    bus.inst_ready   = $urandom_range(0, 99) < p_ready;
    #1;
    live = bus.mem_rvalid && m_busy && (pend_epoch == epoch) && !bus.redirect && !rst;
    byp  = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp  = live && (mq_pc.size() == 0);
`endif
    e_req   = !rst && !m_busy && (mq_pc.size() < DEPTH);
    e_valid = !rst && ((mq_pc.size() != 0) || byp);
    e_pc    = byp ? pend_addr : ((mq_pc.size() != 0) ? mq_pc[0] : 64'h0);

    chk("mem_req", 64'(bus.mem_req), 64'(e_req));
    if (e_req) chk("mem_addr", bus.mem_addr, m_fpc);
    chk("inst_valid", 64'(bus.inst_valid), 64'(e_valid));
    if (e_valid) begin
      chk("inst_pc", bus.inst_pc, e_pc);
      chk("inst_data", 64'(bus.inst_data), 64'(fdata(e_pc)));
    end

    granted = e_req && bus.mem_gnt;
    popped  = e_valid && bus.inst_ready && !bus.redirect;

    if (popped) begin
      pop_log.push_back(e_pc);
      if (!byp) void'(mq_pc.pop_front());
    end
    if (live && !(byp && bus.inst_ready)) mq_pc.push_back(pend_addr);
    if (bus.mem_rvalid && m_busy) m_busy = 1'b0;

    if (bus.mem_rvalid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (granted) begin
      gnt_log.push_back(m_fpc);
      m_busy     = 1'b1;
      mem_pend   = 1'b1;
      pend_addr  = m_fpc;
      pend_epoch = epoch;
      mem_cnt    = $urandom_range(lat_min, lat_max) - 1;
      m_fpc      = m_fpc + 64'd4;
    end

    if (rst) begin
      mq_pc.delete();
      m_busy = 1'b0;
      m_fpc  = 64'h0;
      epoch++;
    end else if (bus.redirect) begin
      mq_pc.delete();
      m_fpc = bus.redirect_pc & ~64'h3;
      epoch++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    force_rst = 1'b1;
    run(2);
    force_rst = 1'b0;
    gnt_log.delete();
    pop_log.delete();
  endtask

  function automatic logic [63:0] at(input logic [63:0] q [$], input int idx);
    return (idx < q.size()) ? q[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    force_rst = 1'b0; force_redir = 1'b0; redir_target = '0;
    p_gnt = 100; p_ready = 100; p_redir = 0; p_rst = 0; lat_min = 2; lat_max = 2;
    m_fpc = '0; m_busy = 1'b0; epoch = 0; mem_pend = 1'b0; mem_cnt = 0;
    pend_addr = '0; pend_epoch = 0;

    // sequential streaming
    do_reset();
    run(30);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", at(gnt_log, i), 64'(4 * i));
      chk("seq_pc", at(pop_log, i), 64'(4 * i));
    end

    // back-pressure fills exactly DEPTH entries, then drains in order
    p_ready = 0;
    do_reset();
    run(30);
    chk("fill_grants", 64'(gnt_log.size()), 64'd4);
    chk("fill_req_low", 64'(bus.mem_req), 64'd0);
    chk("fill_valid", 64'(bus.inst_valid), 64'd1);
    p_ready = 100;
    run(20);
    for (int i = 0; i < 4; i++) chk("drain_pc", at(pop_log, i), 64'(4 * i));
    chk("resume_addr", at(gnt_log, 4), 64'h10);

    // redirect coinciding with a grant
    n = 0;
    while (!(!m_busy && !mem_pend && mq_pc.size() < DEPTH) && n < 100) begin step(); n++; end
    chk("wait_req_bound", 64'(n < 100), 64'd1);
    gnt_log.delete();
    force_redir = 1'b1; redir_target = 64'h203;
    step();
    force_redir = 1'b0;
    chk("redir_gnt_same_cycle", 64'(gnt_log.size()), 64'd1);
    gnt_log.delete(); pop_log.delete();
    run(15);
    chk("redir_gnt_addr", at(gnt_log, 0), 64'h200);
    chk("redir_gnt_pc", at(pop_log, 0), 64'h200);

    // redirect while a response is still owed
    n = 0;
    while (!(m_busy && mem_pend && mem_cnt > 0) && n < 100) begin step(); n++; end
    chk("wait_busy_bound", 64'(n < 100), 64'd1);
    gnt_log.delete();
    force_redir = 1'b1; redir_target = 64'h100;
    step();
    force_redir = 1'b0;
    chk("redir_wait_nogrant", 64'(gnt_log.size()), 64'd0);
    @(posedge clk); #1;
    chk("redir_flush_empty", 64'(bus.inst_valid), 64'd0);
    gnt_log.delete(); pop_log.delete();
    run(15);
    chk("redir_wait_addr", at(gnt_log, 0), 64'h100);
    chk("redir_wait_pc", at(pop_log, 0), 64'h100);

    // fetch address wraps modulo 2^64
    force_redir = 1'b1; redir_target = 64'hFFFF_FFFF_FFFF_FFFA;
    step();
    force_redir = 1'b0;
    gnt_log.delete(); pop_log.delete();
    run(20);
    chk("wrap_a0", at(gnt_log, 0), 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_a1", at(gnt_log, 1), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_a2", at(gnt_log, 2), 64'h0);
    chk("wrap_a3", at(gnt_log, 3), 64'h4);

    // randomized traffic with redirects and resets
    p_gnt = 60; p_ready = 60; p_redir = 30; p_rst = 5; lat_min = 1; lat_max = 4;
    run(20000);
    p_ready = 15; p_redir = 10;
    run(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage that sits directly upstream of the single-cycle core's instruction port.
- Issues sequential 32-bit instruction reads to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Buffers returned {pc, instr} pairs in a small FIFO and presents them to the core with valid/ready.
- On a taken branch/jump redirect, flushes buffered and in-flight fetches and restarts at the new PC.

Parameters:
XLEN, 64, address/PC width
DEPTH, 4, queue entries (power of two, >=2)
RESET_PC, 64'h0, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset; synchronous, active-high
mem_req  output  1  fetch request valid
mem_addr  output  XLEN  fetch address, word aligned
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid (one response per granted request, in order)
mem_rdata  input  32  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  core consumes head
inst_data  output  32  head instruction
inst_pc  output  XLEN  head instruction address
redirect  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch PC; bits[1:0] forced to 0

Behaviour:
- Reset (clk edge with rst=1):
  - fpc=RESET_PC; state=REQ; count=0; rd/wr pointers=0.
  - mem_req=0 and inst_valid=0 during the reset cycle.
  - rst overrides redirect and all handshakes.
- At most one outstanding memory request.
- FSM states:
  - REQ:
    - mem_req=1 iff count<DEPTH; mem_addr=fpc; inflight_pc<=fpc on grant.
    - mem_req&mem_gnt: fpc<=fpc+4, go WAIT.
    - mem_addr is held stable while mem_req=1 and not granted.
  - WAIT:
    - mem_req=0.
    - mem_rvalid: push {inflight_pc, mem_rdata}, go REQ.
  - DROP:
    - mem_req=0.
    - mem_rvalid: discard data, go REQ.
- Redirect (highest priority after rst):
  - count<=0 and pointers reset.
  - fpc<=redirect_pc&~3.
  - Any push or pop in the same cycle is suppressed.
- Next state on redirect:
  - WAIT -> DROP.
  - REQ with mem_gnt in same cycle -> DROP (the accepted request's data is stale); fpc still <= redirect_pc.
  - REQ without grant -> REQ; new address presented next cycle.
  - DROP -> DROP; mem_rvalid in that same cycle ends DROP -> REQ.
- Queue:
  - Pop on inst_valid&inst_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full never occurs, because requests are gated by count<DEPTH; the accepted request's slot is reserved, i.e. request only if count+(state==WAIT)<DEPTH. In REQ this reduces to count<DEPTH.
  - Pointers wrap modulo DEPTH.
- Outputs:
  - inst_valid=(count!=0); inst_data/inst_pc come from the head entry.
  - Head entry is stable while inst_valid&!inst_ready.
- Latency: mem_rvalid at cycle t -> inst_valid=1 at t+1 with that data.
- PC arithmetic is modulo 2^XLEN: fpc wraps from all-ones-minus-3 to 0.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count==0, state==WAIT, mem_rvalid=1 and no redirect: inst_valid=1 combinationally that cycle, with inst_data=mem_rdata and inst_pc=inflight_pc.
  - If inst_ready=1 in that cycle, the word is not pushed; otherwise it is pushed normally.
  - Zero-cycle fetch-to-issue latency.
- Undefined: inst_valid depends only on registered state (1-cycle latency as above).

Test Plan:
- Reset, then mem_gnt=1 always, rvalid 2 cycles after each grant, inst_ready=1 -> mem_addr sequence 0,4,8,12; inst_pc sequence 0,4,8,12 with matching inst_data; no duplicates or gaps.
- inst_ready=0 with DEPTH=4 -> exactly 4 requests granted, then mem_req=0 and count=4; raise inst_ready -> head pops in order 0,4,8,12, fetch resumes at 16.
- Redirect to 0x100 while state=WAIT (request for 0x8 in flight) -> 0x8 response discarded; next mem_addr=0x100; first inst_pc after redirect=0x100; queue empty in the cycle after redirect.
- Redirect to 0x203 in the same cycle mem_gnt accepts 0x10 -> state=DROP; response for 0x10 discarded; next mem_addr=0x200.
- rst asserted mid-WAIT with 2 entries queued -> next cycle inst_valid=0, mem_req=0; following cycle mem_addr=RESET_PC; late rvalid from the old request while in REQ is ignored.
- IFQ_BYPASS_EN: empty queue, rvalid with rdata=0x00000013 at cycle t -> inst_valid=1, inst_data=0x00000013 at cycle t; with inst_ready=1, count remains 0.
